// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle control FSM: states, mux selects,
// instruction classes and the decoded control word.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       regw;
        logic       memw;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/flopr.sv
// Resettable D register with synchronous active-low reset to zero.
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (!reset) q_o <= '0;
        else        q_o <= d_i;
    end

endmodule

// File: rtl/mainfsm_outdec.sv
// Moore decode of the FSM state into the datapath control word; only the
// FETCH strobes and MemW also depend on MemReady.
module mainfsm_outdec
    import mainfsm_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       memready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.alusrca   = 1'b1;
                ctrl_o.alusrcb   = SRCB_FOUR;
                ctrl_o.resultsrc = RES_ALU;
                ctrl_o.irwrite   = memready_i;
                ctrl_o.nextpc    = memready_i;
            end
            // PC+8 is produced here for the R15 read path.
            S_DECODE: begin
                ctrl_o.alusrca   = 1'b1;
                ctrl_o.alusrcb   = SRCB_FOUR;
                ctrl_o.resultsrc = RES_ALU;
            end
            S_MEMADR: ctrl_o.alusrcb = SRCB_IMM;
            S_MEMRD: begin
                ctrl_o.adrsrc    = 1'b1;
                ctrl_o.resultsrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl_o.resultsrc = RES_DATA;
                ctrl_o.regw      = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.adrsrc    = 1'b1;
                ctrl_o.resultsrc = RES_ALUOUT;
                ctrl_o.memw      = memready_i;
            end
            S_EXECR: begin
                ctrl_o.alusrcb = SRCB_REG;
                ctrl_o.aluop   = 1'b1;
            end
            S_EXECI: begin
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = 1'b1;
            end
            S_ALUWB: begin
                ctrl_o.resultsrc = RES_ALUOUT;
                ctrl_o.regw      = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alusrcb   = SRCB_IMM;
                ctrl_o.resultsrc = RES_ALU;
                ctrl_o.branch    = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// Multicycle ARM main control FSM: next-state logic, retired-instruction
// counter and reset-qualified control outputs.
module mainfsm
    import mainfsm_pkg::*;
#(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      Op,
    input  logic [5:0]      Funct,
    input  logic            MemReady,
    output logic            IRWrite,
    output logic            AdrSrc,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ResultSrc,
    output logic            ALUOp,
    output logic            NextPC,
    output logic            RegW,
    output logic            MemW,
    output logic            Branch,
    output logic [3:0]      State,
    output logic [CNTW-1:0] InstrCount
);

    logic [3:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            retire;
    ctrl_t           ctrl;
    logic            unused_funct;

    assign unused_funct = ^Funct[4:1];

    flopr #(.WIDTH(4)) u_state (
        .clk   (clk),
        .reset (reset),
        .d_i   (state_d),
        .q_o   (state_q)
    );

    flopr #(.WIDTH(CNTW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .d_i   (cnt_d),
        .q_o   (cnt_q)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Unreachable encodings also fall back to FETCH but do not retire anything.
    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_DECODE, S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
        cnt_d = retire ? cnt_q + CNTW'(1) : cnt_q;
    end

    mainfsm_outdec u_outdec (
        .state_i    (state_q),
        .memready_i (MemReady),
        .ctrl_o     (ctrl)
    );

    // Strobes are forced low while reset is held so nothing leaks out before
    // the first clean FETCH.
    assign IRWrite    = ctrl.irwrite & reset;
    assign NextPC     = ctrl.nextpc  & reset;
    assign RegW       = ctrl.regw    & reset;
    assign MemW       = ctrl.memw    & reset;
    assign Branch     = ctrl.branch  & reset;
    assign AdrSrc     = ctrl.adrsrc;
    assign ALUSrcA    = ctrl.alusrca;
    assign ALUSrcB    = ctrl.alusrcb;
    assign ResultSrc  = ctrl.resultsrc;
    assign ALUOp      = ctrl.aluop;
    assign State      = state_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_mainfsm.sv
// Directed bench for mainfsm: a vector table for the main instruction
// classes plus hand sequences for immediate ops, reset abort, wrap and store stall.
module tb_mainfsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;

    logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;
    logic [31:0] InstrCount;

    logic       IRWrite4, AdrSrc4, ALUSrcA4, ALUOp4, NextPC4, RegW4, MemW4, Branch4;
    logic [1:0] ALUSrcB4, ResultSrc4;
    logic [3:0] State4;
    logic [3:0] InstrCount4;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mainfsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .State(State), .InstrCount(InstrCount)
    );

    mainfsm #(.CNTW(4)) dut4 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite4), .AdrSrc(AdrSrc4), .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4),
        .ResultSrc(ResultSrc4), .ALUOp(ALUOp4), .NextPC(NextPC4), .RegW(RegW4),
        .MemW(MemW4), .Branch(Branch4), .State(State4), .InstrCount(InstrCount4)
    );

    typedef struct {
        logic        r;
        logic [1:0]  op;
        logic [5:0]  f;
        logic        mr;
        logic [3:0]  st;
        logic [4:0]  sb;   // {IRWrite, NextPC, RegW, MemW, Branch}
        logic [31:0] cnt;
    } vec_t;

    vec_t tv[26];

    function automatic vec_t mk(logic r, logic [1:0] op, logic [5:0] f, logic mr,
                                logic [3:0] st, logic [4:0] sb, logic [31:0] cnt);
        vec_t v;
        v.r = r; v.op = op; v.f = f; v.mr = mr; v.st = st; v.sb = sb; v.cnt = cnt;
        return v;
    endfunction

    // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp} transcribed from the state table.
    function automatic logic [6:0] exp_mux(logic [3:0] st);
        case (st)
            4'd0, 4'd1: return 7'b0_1_10_10_0;
            4'd2:       return 7'b0_0_01_00_0;
            4'd3, 4'd5: return 7'b1_0_00_00_0;
            4'd4:       return 7'b0_0_00_01_0;
            4'd6:       return 7'b0_0_00_00_1;
            4'd7:       return 7'b0_0_01_00_1;
            4'd9:       return 7'b0_0_01_10_0;
            default:    return 7'b0_0_00_00_0;
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic r, input logic [1:0] op,
                       input logic [5:0] f, input logic mr, input logic [3:0] st,
                       input logic [4:0] sb, input logic [31:0] cnt);
        reset = r; Op = op; Funct = f; MemReady = mr;
        @(negedge clk);
        cmp({nm, ".state"}, 32'(State), 32'(st));
        cmp({nm, ".strobes"}, 32'({IRWrite, NextPC, RegW, MemW, Branch}), 32'(sb));
        cmp({nm, ".mux"}, 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}), 32'(exp_mux(st)));
        cmp({nm, ".cnt"}, InstrCount, cnt);
        cmp({nm, ".cnt4"}, 32'(InstrCount4), 32'(cnt[3:0]));
        @(posedge clk); #1;
    endtask

    initial begin
        tv[0]  = mk(0, 2'b00, 6'b000100, 1, 0, 5'b00000, 0);
        tv[1]  = mk(0, 2'b00, 6'b000100, 1, 0, 5'b00000, 0);
        tv[2]  = mk(1, 2'b00, 6'b000100, 1, 0, 5'b11000, 0);
        tv[3]  = mk(1, 2'b00, 6'b000100, 1, 1, 5'b00000, 0);
        tv[4]  = mk(1, 2'b00, 6'b000100, 1, 6, 5'b00000, 0);
        tv[5]  = mk(1, 2'b00, 6'b000100, 1, 8, 5'b00100, 0);
        tv[6]  = mk(1, 2'b01, 6'b011001, 1, 0, 5'b11000, 1);
        tv[7]  = mk(1, 2'b01, 6'b011001, 1, 1, 5'b00000, 1);
        tv[8]  = mk(1, 2'b01, 6'b011001, 1, 2, 5'b00000, 1);
        tv[9]  = mk(1, 2'b01, 6'b011001, 0, 3, 5'b00000, 1);
        tv[10] = mk(1, 2'b01, 6'b011001, 0, 3, 5'b00000, 1);
        tv[11] = mk(1, 2'b01, 6'b011001, 1, 3, 5'b00000, 1);
        tv[12] = mk(1, 2'b01, 6'b011001, 1, 4, 5'b00100, 1);
        tv[13] = mk(1, 2'b01, 6'b011000, 0, 0, 5'b00000, 2);
        tv[14] = mk(1, 2'b01, 6'b011000, 0, 0, 5'b00000, 2);
        tv[15] = mk(1, 2'b01, 6'b011000, 0, 0, 5'b00000, 2);
        tv[16] = mk(1, 2'b01, 6'b011000, 1, 0, 5'b11000, 2);
        tv[17] = mk(1, 2'b01, 6'b011000, 1, 1, 5'b00000, 2);
        tv[18] = mk(1, 2'b01, 6'b011000, 1, 2, 5'b00000, 2);
        tv[19] = mk(1, 2'b01, 6'b011000, 1, 5, 5'b00010, 2);
        tv[20] = mk(1, 2'b10, 6'b000000, 1, 0, 5'b11000, 3);
        tv[21] = mk(1, 2'b10, 6'b000000, 1, 1, 5'b00000, 3);
        tv[22] = mk(1, 2'b10, 6'b000000, 1, 9, 5'b00001, 3);
        tv[23] = mk(1, 2'b11, 6'b000000, 1, 0, 5'b11000, 4);
        tv[24] = mk(1, 2'b11, 6'b000000, 1, 1, 5'b00000, 4);
        tv[25] = mk(1, 2'b00, 6'b101000, 1, 0, 5'b11000, 5);

        // One reset edge so State is defined before the first sample.
        reset = 1'b0; Op = 2'b00; Funct = 6'b000100; MemReady = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 26; i++)
            cyc($sformatf("tv%0d", i), tv[i].r, tv[i].op, tv[i].f, tv[i].mr,
                tv[i].st, tv[i].sb, tv[i].cnt);

        // Immediate data-processing: DECODE -> EXECI -> ALUWB.
        cyc("addi.dec",  1, 2'b00, 6'b101000, 1, 1, 5'b00000, 5);
        cyc("addi.exec", 1, 2'b00, 6'b101000, 1, 7, 5'b00000, 5);
        cyc("addi.wb",   1, 2'b00, 6'b101000, 1, 8, 5'b00100, 5);

        // Reset asserted while a load waits in MEMRD.
        cyc("ldrr.fetch", 1, 2'b01, 6'b011001, 1, 0, 5'b11000, 6);
        cyc("ldrr.dec",   1, 2'b01, 6'b011001, 1, 1, 5'b00000, 6);
        cyc("ldrr.adr",   1, 2'b01, 6'b011001, 1, 2, 5'b00000, 6);
        cyc("ldrr.rd",    0, 2'b01, 6'b011001, 0, 3, 5'b00000, 6);
        cyc("ldrr.post",  1, 2'b01, 6'b011001, 0, 0, 5'b00000, 0);

        // Sixteen undefined instructions wrap the 4-bit counter.
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("wrap%0d.f", i), 1, 2'b11, 6'b000000, 1, 0, 5'b11000, 32'(i));
            cyc($sformatf("wrap%0d.d", i), 1, 2'b11, 6'b000000, 1, 1, 5'b00000, 32'(i));
        end

        // Store stalled in MEMWR: MemW only on the completing cycle.
        cyc("strw.fetch", 1, 2'b01, 6'b011000, 1, 0, 5'b11000, 16);
        cyc("strw.dec",   1, 2'b01, 6'b011000, 1, 1, 5'b00000, 16);
        cyc("strw.adr",   1, 2'b01, 6'b011000, 1, 2, 5'b00000, 16);
        cyc("strw.wr0",   1, 2'b01, 6'b011000, 0, 5, 5'b00000, 16);
        cyc("strw.wr1",   1, 2'b01, 6'b011000, 1, 5, 5'b00010, 16);
        cyc("strw.done",  1, 2'b00, 6'b000000, 0, 0, 5'b00000, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
